// File: rtl/dvi_pkg.sv
// -----------------------------------------------------------------------------
// dvi_pkg
// Shared constants for the DVI TMDS encoder: symbol width, pipeline latency
// and the four control tokens sent during blanking, plus a helper that maps
// the {c1,c0} control pair onto its token.
// -----------------------------------------------------------------------------
package dvi_pkg;

  localparam int SYM_W        = 10;
  localparam int PIPE_LATENCY = 3;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  // {c1,c0} -> control token
  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] i_ctrl);
    logic [SYM_W-1:0] w_tok;
    case (i_ctrl)
      2'b00:   w_tok = CTRL_TOKEN_00;
      2'b01:   w_tok = CTRL_TOKEN_01;
      2'b10:   w_tok = CTRL_TOKEN_10;
      default: w_tok = CTRL_TOKEN_11;
    endcase
    return w_tok;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// -----------------------------------------------------------------------------
// tmds_channel
// One TMDS 8b/10b encoder lane with its own running-disparity counter.
// Three register stages:
//   stage 1: capture data/de/control, count ones in the data byte
//   stage 2: transition-minimising q_m[8:0] and its ones count
//   stage 3: DC-balancing symbol select, disparity update, output register
// Ports:
//   i_clk    pixel clock
//   i_reset  synchronous, active-high
//   i_data   8-bit colour component
//   i_de     data enable (0 = send control token)
//   i_ctrl   {c1,c0} control pair used while i_de = 0
//   o_sym    10-bit symbol, bit 0 transmitted first
// -----------------------------------------------------------------------------
module tmds_channel
  import dvi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_data,
  input  logic             i_de,
  input  logic [1:0]       i_ctrl,
  output logic [SYM_W-1:0] o_sym
);

  // ---------------- stage 1 ----------------
  logic [7:0] r_s1_data;
  logic       r_s1_de;
  logic [1:0] r_s1_ctrl;
  logic [3:0] r_s1_n1d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_data <= '0;
      r_s1_de   <= 1'b0;
      r_s1_ctrl <= 2'b00;
      r_s1_n1d  <= '0;
    end else begin
      r_s1_data <= i_data;
      r_s1_de   <= i_de;
      r_s1_ctrl <= i_ctrl;
      r_s1_n1d  <= 4'($countones(i_data));
    end
  end

  // ---------------- stage 2 ----------------
  logic       w_use_xnor;
  logic [8:0] w_qm;

  // XNOR chain when the byte is ones-heavy (ties broken by D[0]) so that
  // q_m ends up with fewer transitions.
  assign w_use_xnor = (r_s1_n1d > 4'd4) || ((r_s1_n1d == 4'd4) && !r_s1_data[0]);

  always_comb begin
    w_qm    = '0;
    w_qm[0] = r_s1_data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_s1_data[i]) : (w_qm[i-1] ^ r_s1_data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  logic [8:0] r_s2_qm;
  logic [3:0] r_s2_n1;
  logic       r_s2_de;
  logic [1:0] r_s2_ctrl;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_qm   <= '0;
      r_s2_n1   <= '0;
      r_s2_de   <= 1'b0;
      r_s2_ctrl <= 2'b00;
    end else begin
      r_s2_qm   <= w_qm;
      r_s2_n1   <= 4'($countones(w_qm[7:0]));
      r_s2_de   <= r_s1_de;
      r_s2_ctrl <= r_s1_ctrl;
    end
  end

  // ---------------- stage 3 ----------------
  logic signed [4:0] r_cnt;
  logic signed [4:0] w_diff;      // n1 - n0 = 2*n1 - 8, range [-8,+8]
  logic signed [4:0] w_cnt_next;
  logic [SYM_W-1:0]  w_sym;
  logic [SYM_W-1:0]  r_sym;
  logic              w_q8;
  logic [7:0]        w_q;

  assign w_q8   = r_s2_qm[8];
  assign w_q    = r_s2_qm[7:0];
  assign w_diff = $signed({r_s2_n1, 1'b0} - 5'd8);

  always_comb begin
    w_sym      = ctrl_token(r_s2_ctrl);
    w_cnt_next = 5'sd0;            // blanking clears the disparity
    if (r_s2_de) begin
      if ((r_cnt == 5'sd0) || (w_diff == 5'sd0)) begin
        w_sym      = {~w_q8, w_q8, (w_q8 ? w_q : ~w_q)};
        w_cnt_next = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (((r_cnt > 5'sd0) && (w_diff > 5'sd0)) ||
                   ((r_cnt < 5'sd0) && (w_diff < 5'sd0))) begin
        // Running disparity and this word lean the same way: invert.
        w_sym      = {1'b1, w_q8, ~w_q};
        w_cnt_next = r_cnt - w_diff + (w_q8 ? 5'sd2 : 5'sd0);
      end else begin
        w_sym      = {1'b0, w_q8, w_q};
        w_cnt_next = r_cnt + w_diff - (w_q8 ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 5'sd0;
      r_sym <= CTRL_TOKEN_00;
    end else begin
      r_cnt <= w_cnt_next;
      r_sym <= w_sym;
    end
  end

  assign o_sym = r_sym;

endmodule

// File: rtl/dvi_tmds_encode.sv
// -----------------------------------------------------------------------------
// dvi_tmds_encode
// Three-lane TMDS encoder for a DVI link. Maps the pixel stream onto three
// tmds_channel lanes (B/G/R) and delays DE to line up with the symbols.
// Ports:
//   clk_dot            pixel clock
//   reset              synchronous, active-high
//   pix_rgb[23:0]      {R,G,B}, used only while pix_de = 1
//   pix_de             data enable
//   pix_hsync/vsync    sync, carried on ch0 control tokens as {vs,hs}
//   tmds_ch0/1/2       blue/green/red 10-bit symbols, bit 0 first
//   tmds_de            pix_de aligned with the symbols
// -----------------------------------------------------------------------------
module dvi_tmds_encode
  import dvi_pkg::*;
(
  input  logic             clk_dot,
  input  logic             reset,
  input  logic [23:0]      pix_rgb,
  input  logic             pix_de,
  input  logic             pix_hsync,
  input  logic             pix_vsync,
  output logic [SYM_W-1:0] tmds_ch0,
  output logic [SYM_W-1:0] tmds_ch1,
  output logic [SYM_W-1:0] tmds_ch2,
  output logic             tmds_de
);

  logic [SYM_W-1:0] w_sym [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [1:0] w_ctrl;
      // Only the blue lane carries sync; the others send token 00.
      if (gi == 0) begin : g_sync
        assign w_ctrl = {pix_vsync, pix_hsync};
      end else begin : g_nosync
        assign w_ctrl = 2'b00;
      end

      tmds_channel u_ch (
        .i_clk   (clk_dot),
        .i_reset (reset),
        .i_data  (pix_rgb[gi*8 +: 8]),
        .i_de    (pix_de),
        .i_ctrl  (w_ctrl),
        .o_sym   (w_sym[gi])
      );
    end
  endgenerate

  assign tmds_ch0 = w_sym[0];
  assign tmds_ch1 = w_sym[1];
  assign tmds_ch2 = w_sym[2];

  logic [PIPE_LATENCY-1:0] r_de_pipe;

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      r_de_pipe <= '0;
    end else begin
      r_de_pipe <= {r_de_pipe[PIPE_LATENCY-2:0], pix_de};
    end
  end

  assign tmds_de = r_de_pipe[PIPE_LATENCY-1];

endmodule
